// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential 8x8 Vedic multiplier:
// operand/product widths and the controller state encoding.
package vedic_pkg;

   localparam int OP_W   = 8;
   localparam int HALF_W = 4;
   localparam int PROD_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      PP0,
      PP1,
      PP2,
      PP3,
      DONE
   } state_e;

endpackage : vedic_pkg

// File: rtl/vedic_mult4.sv
// Combinational 4x4 unsigned multiplier built Urdhva-Tiryagbhyam style
// from four 2x2 Vedic cells whose vertical/crosswise sums are merged.
import vedic_pkg::*;

module vedic_mult4 (
   input  logic [HALF_W-1:0]   x,
   input  logic [HALF_W-1:0]   y,
   output logic [2*HALF_W-1:0] p
);

   // 2x2 Vedic cell: vertical LSB, crosswise middle, vertical MSB plus carry
   function automatic logic [3:0] mult2(input logic [1:0] u, input logic [1:0] v);
      logic p0, s1, c1, s2, c2;
      p0 = u[0] & v[0];
      s1 = (u[1] & v[0]) ^ (u[0] & v[1]);
      c1 = (u[1] & v[0]) & (u[0] & v[1]);
      s2 = (u[1] & v[1]) ^ c1;
      c2 = (u[1] & v[1]) & c1;
      return {c2, s2, s1, p0};
   endfunction

   logic [3:0] q0, q1, q2, q3;
   logic [4:0] mid;
   logic [3:0] hi;

   // Combine the four 2x2 products: q0 + (q1 + q2) << 2 + q3 << 4
   always_comb begin
      q0  = mult2(x[1:0], y[1:0]);
      q1  = mult2(x[3:2], y[1:0]);
      q2  = mult2(x[1:0], y[3:2]);
      q3  = mult2(x[3:2], y[3:2]);
      mid = {1'b0, q1} + {1'b0, q2} + {3'b000, q0[3:2]};
      hi  = q3 + {1'b0, mid[4:2]};
      p   = {hi, mid[1:0], q0[1:0]};
   end

endmodule : vedic_mult4

// File: rtl/vedic_mult_seq8.sv
// Sequential 8x8 unsigned multiplier: one 4x4 Vedic core is reused over
// four partial-product cycles (PP0..PP3) into a 16-bit accumulator.
// Optional macro VEDIC_APPROX_EN: the low APPROX_BITS of each accumulate
// are OR-ed instead of added (no carry out of that field).
import vedic_pkg::*;

module vedic_mult_seq8 #(
   parameter int APPROX_BITS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product
);

   if (APPROX_BITS < 1 || APPROX_BITS > 15) begin : g_bad_approx_bits
      $error("vedic_mult_seq8: APPROX_BITS must be within 1..15");
   end

   state_e                   state_q, state_d;
   logic [OP_W-1:0]          a_q, a_d, b_q, b_d;
   logic [PROD_W-1:0]        acc_q, acc_d;
   logic [HALF_W-1:0]        m_x, m_y;
   logic [2*HALF_W-1:0]      pp;
   logic [PROD_W-1:0]        addend;
   logic [PROD_W-1:0]        acc_sum;
   logic                     accept;

   vedic_mult4 u_mult4 (
      .x (m_x),
      .y (m_y),
      .p (pp)
   );

   // Select operand halves for the shared core and align its result
   always_comb begin
      m_x    = a_q[HALF_W-1:0];
      m_y    = b_q[HALF_W-1:0];
      addend = PROD_W'(pp);
      case (state_q)
         PP1: begin
            m_x    = a_q[OP_W-1:HALF_W];
            addend = PROD_W'(pp) << HALF_W;
         end
         PP2: begin
            m_y    = b_q[OP_W-1:HALF_W];
            addend = PROD_W'(pp) << HALF_W;
         end
         PP3: begin
            m_x    = a_q[OP_W-1:HALF_W];
            m_y    = b_q[OP_W-1:HALF_W];
            addend = PROD_W'(pp) << OP_W;
         end
         default: ;
      endcase
   end

`ifdef VEDIC_APPROX_EN
   localparam logic [PROD_W-1:0] LO_MASK = PROD_W'((32'd1 << APPROX_BITS) - 32'd1);

   // Approximate accumulate: OR in the low field, exact add above it
   always_comb begin
      acc_sum = ((acc_q | addend) & LO_MASK)
              | (((acc_q & ~LO_MASK) + (addend & ~LO_MASK)) & ~LO_MASK);
   end
`else
   // Exact accumulate; carry out of bit 15 is dropped
   always_comb begin
      acc_sum = acc_q + addend;
   end
`endif

   // Handshake outputs; in_ready is held low while reset is asserted
   always_comb begin
      in_ready  = (state_q == IDLE) && rst_n;
      out_valid = (state_q == DONE);
      product   = out_valid ? acc_q : '0;
      accept    = in_valid && in_ready;
   end

   // Next-state and datapath update for the controller
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               state_d = PP0;
            end
         end
         PP0: begin
            acc_d   = acc_sum;
            state_d = PP1;
         end
         PP1: begin
            acc_d   = acc_sum;
            state_d = PP2;
         end
         PP2: begin
            acc_d   = acc_sum;
            state_d = PP3;
         end
         PP3: begin
            acc_d   = acc_sum;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
      end
   end

endmodule : vedic_mult_seq8

// File: tb/tb_vedic_mult_seq8.sv
// Self-checking bench for vedic_mult_seq8 (builds with or without VEDIC_APPROX_EN).
module tb_vedic_mult_seq8;

   localparam int APPROX_BITS = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [7:0]  a = 8'h00;
   logic [7:0]  b = 8'h00;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] product;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vedic_mult_seq8 #(.APPROX_BITS(APPROX_BITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference product: arithmetic product mod 2^16, or the OR-low-field rule
   function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y);
`ifdef VEDIC_APPROX_EN
      logic [15:0] acc;
      logic [15:0] mask;
      logic [15:0] term;
      int          xs;
      int          ys;
      acc  = 16'h0000;
      mask = 16'((32'd1 << APPROX_BITS) - 32'd1);
      for (int k = 0; k < 4; k++) begin
         xs   = (k == 1 || k == 3) ? 4 : 0;
         ys   = (k >= 2) ? 4 : 0;
         term = 16'(((32'(x) >> xs) & 32'd15) * ((32'(y) >> ys) & 32'd15) << (xs + ys));
         acc  = ((acc | term) & mask) | (((acc & ~mask) + (term & ~mask)) & ~mask);
      end
      return acc;
`else
      return 16'((32'(x) * 32'(y)) & 32'h0000FFFF);
`endif
   endfunction

   // One full transaction from IDLE, with latency and handshake checks
   task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input bit noise,
                         input logic [15:0] expp, input string tag);
      int lat;
      check({tag, " in_ready_idle"}, 16'(in_ready), 16'd1);
      a        = xa;
      b        = xb;
      in_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 20) begin
         check({tag, " in_ready_busy"}, 16'(in_ready), 16'd0);
         if (noise) begin
            in_valid = 1'($urandom);
            a        = 8'($urandom);
            b        = 8'($urandom);
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check({tag, " latency"}, 16'(lat), 16'd5);
      check({tag, " product"}, product, expp);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " out_valid_after"}, 16'(out_valid), 16'd0);
      check({tag, " product_zero"}, product, 16'h0000);
      check({tag, " in_ready_after"}, 16'(in_ready), 16'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  xa, xb;
      logic [15:0] held;
      int          guard;

      // Reset state
      #12;
      check("rst in_ready", 16'(in_ready), 16'd0);
      check("rst out_valid", 16'(out_valid), 16'd0);
      check("rst product", product, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel in_ready", 16'(in_ready), 16'd1);
      @(negedge clk);

      // Directed operands
`ifdef VEDIC_APPROX_EN
      run_op(8'hFF, 8'hFF, 1'b0, 16'hFDF1, "apx_ff_ff");
      run_op(8'h0F, 8'h0F, 1'b0, 16'h00E1, "apx_0f_0f");
`else
      run_op(8'd200, 8'd150, 1'b0, 16'h7530, "ex_200_150");
      run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "ex_ff_ff");
      run_op(8'h00, 8'hAB, 1'b0, 16'h0000, "ex_00_ab");
`endif
      run_op(8'hAB, 8'h00, 1'b0, ref_prod(8'hAB, 8'h00), "b_zero");
      run_op(8'h80, 8'h01, 1'b0, ref_prod(8'h80, 8'h01), "msb_x1");

      // Random operands with in_valid/a/b noise while busy
      for (int i = 0; i < 24; i++) begin
         xa = 8'($urandom);
         xb = 8'($urandom);
         run_op(xa, xb, 1'b1, ref_prod(xa, xb), "rand");
      end

      // Backpressure: hold DONE for 10 cycles with in_valid pulses
      a = 8'hC3; b = 8'h5A; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("bp reached_done", 16'(out_valid), 16'd1);
      held = product;
      check("bp product", held, ref_prod(8'hC3, 8'h5A));
      for (int i = 0; i < 10; i++) begin
         in_valid = ~in_valid;
         a = 8'($urandom);
         b = 8'($urandom);
         @(posedge clk);
         @(negedge clk);
         check("bp stable", product, ref_prod(8'hC3, 8'h5A));
         check("bp out_valid", 16'(out_valid), 16'd1);
         check("bp in_ready", 16'(in_ready), 16'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("bp idle in_ready", 16'(in_ready), 16'd1);
      check("bp idle out_valid", 16'(out_valid), 16'd0);

      // Asynchronous reset while holding a product in DONE
      a = 8'hE7; b = 8'h9D; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("rdone out_valid_pre", 16'(out_valid), 16'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rdone out_valid", 16'(out_valid), 16'd0);
      check("rdone product", product, 16'h0000);
      check("rdone in_ready", 16'(in_ready), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rdone rel in_ready", 16'(in_ready), 16'd1);
      @(negedge clk);

      // Asynchronous reset in PP2, then a fresh operation
      a = 8'h55; b = 8'h66; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rpp2 out_valid", 16'(out_valid), 16'd0);
      check("rpp2 product", product, 16'h0000);
      check("rpp2 in_ready", 16'(in_ready), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rpp2 rel in_ready", 16'(in_ready), 16'd1);
      @(negedge clk);
      run_op(8'd3, 8'd7, 1'b0, 16'd21, "post_rst_3x7");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_vedic_mult_seq8
